// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS EX/MEM pipeline stage.
//   DW, RW        : datapath and register-index widths
//   REG_ZERO      : index of the hard-wired zero register
//   exmem_ctl_t   : MEM/WB control bits carried through EX/MEM
//   exmem_entry_t : one full EX/MEM bundle as held by the skid buffer
//   skid_state_t  : skid buffer occupancy, also exported for debug
//   branch_target : pc_plus4 + (imm << 2), truncated to DW
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } exmem_ctl_t;

  typedef struct packed {
    logic [DW-1:0] alu_result;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] pc_target;
    logic [RW-1:0] wr_reg;
    exmem_ctl_t    ctl;
    logic          taken;
  } exmem_entry_t;

  // EMPTY: nothing held; ONE: HEAD only; TWO: HEAD and SKID both held.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [DW-1:0] branch_target(input logic [DW-1:0] pc_plus4,
                                                  input logic [DW-1:0] imm_sext);
    return pc_plus4 + (imm_sext << 2);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_stage interfaces
//   exmem_in_if  : EX -> stage bundle. master = EX stage, slave = ex_mem_stage.
//                  in_valid/in_ready handshake, bundle fields, control, flush.
//   exmem_out_if : stage -> MEM bundle. master = ex_mem_stage, slave = MEM.
//                  out_valid/out_ready handshake, head-entry fields, br_taken,
//                  skid_state (debug view of occupancy), and the forwarding tap
//                  fwd_valid/fwd_reg/fwd_data when EXMEM_FWD_EN is defined.
//
// Handshake: a bundle transfers on a rising edge where valid & ready are both
// 1. The sender keeps valid and the bundle stable until it transfers; ready
// never depends combinationally on valid.
// -----------------------------------------------------------------------------
interface exmem_in_if;
  import mips_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic [DW-1:0] rt_data;
  logic [RW-1:0] wr_reg;
  logic [DW-1:0] pc_plus4;
  logic [DW-1:0] imm_sext;
  logic          ctl_reg_write;
  logic          ctl_mem_read;
  logic          ctl_mem_write;
  logic          ctl_mem_to_reg;
  logic          ctl_branch;
  logic          ctl_branch_ne;
  logic          flush;

  modport master (
    output in_valid, alu_result, alu_zero, rt_data, wr_reg, pc_plus4, imm_sext,
           ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg,
           ctl_branch, ctl_branch_ne, flush,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, rt_data, wr_reg, pc_plus4, imm_sext,
           ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg,
           ctl_branch, ctl_branch_ne, flush,
    output in_ready
  );
endinterface

interface exmem_out_if;
  import mips_pkg::*;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu_result;
  logic [DW-1:0] out_rt_data;
  logic [DW-1:0] out_pc_target;
  logic [RW-1:0] out_wr_reg;
  logic          out_reg_write;
  logic          out_mem_read;
  logic          out_mem_write;
  logic          out_mem_to_reg;
  logic          br_taken;
  skid_state_t   skid_state;
`ifdef EXMEM_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
`endif

  modport master (
    output out_valid, out_alu_result, out_rt_data, out_pc_target, out_wr_reg,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           br_taken, skid_state,
`ifdef EXMEM_FWD_EN
           fwd_valid, fwd_reg, fwd_data,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_alu_result, out_rt_data, out_pc_target, out_wr_reg,
           out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
           br_taken, skid_state,
`ifdef EXMEM_FWD_EN
           fwd_valid, fwd_reg, fwd_data,
`endif
    output out_ready
  );
endinterface

// File: rtl/exmem_skid.sv
// -----------------------------------------------------------------------------
// exmem_skid
// Generic 2-entry skid buffer (HEAD + SKID), parameterised on entry type T.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_flush             : synchronous kill of both entries; forces ready
//   i_valid/o_ready     : upstream handshake, i_data = upstream entry
//   o_valid/i_ready     : downstream handshake, o_data = HEAD entry
//   o_state             : occupancy (debug)
// o_ready is a function of the state register only, so a downstream stall
// never reaches upstream combinationally.
// -----------------------------------------------------------------------------
module exmem_skid
  import mips_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  T            i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output T            o_data,
  output skid_state_t o_state
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  T            r_head;
  T            r_skid;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_load_head_in;
  logic        w_load_head_skid;
  logic        w_load_skid;

  assign o_ready    = (r_state != SKID_TWO);
  assign o_valid    = (r_state != SKID_EMPTY);
  assign o_data     = r_head;
  assign o_state    = r_state;
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SKID_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      // Flush wins over any fire in the same cycle; nothing is loaded.
      w_state_nxt = SKID_EMPTY;
    end else begin
      unique case (r_state)
        SKID_EMPTY: begin
          if (w_in_fire) begin
            w_load_head_in = 1'b1;
            w_state_nxt    = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_head_in = 1'b1;              // replace HEAD, occupancy unchanged
          end else if (w_out_fire) begin
            w_state_nxt = SKID_EMPTY;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = SKID_TWO;
          end
        end
        SKID_TWO: begin
          // o_ready is 0 here, so no input can arrive to refill SKID.
          if (w_out_fire) begin
            w_load_head_skid = 1'b1;
            w_state_nxt      = SKID_ONE;
          end
        end
        default: w_state_nxt = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in)        r_head <= i_data;
      else if (w_load_head_skid) r_head <= r_skid;
      if (w_load_skid)           r_skid <= i_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register behind the MIPS ALU. Packs the ALU result, store
// data, destination register and control into an entry, resolves the branch
// (target adder and taken decision) at capture, and holds entries in a
// 2-entry skid buffer toward the MEM stage.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_ex       : exmem_in_if.slave  (in_valid/in_ready, bundle, flush)
//   o_mem      : exmem_out_if.master (out_valid/out_ready, HEAD fields,
//                br_taken, skid_state, forwarding tap)
// Widths DW/RW come from mips_pkg.
// Optional macro EXMEM_FWD_EN: adds fwd_valid/fwd_reg/fwd_data, taken
// combinationally from HEAD for the EX forwarding mux.
// -----------------------------------------------------------------------------
module ex_mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exmem_in_if.slave   i_ex,
  exmem_out_if.master o_mem
);

  exmem_entry_t w_in_entry;
  exmem_entry_t w_head;
  logic         w_head_valid;

  // Taken: BEQ needs zero, BNE needs non-zero.
  always_comb begin
    w_in_entry                = '0;
    w_in_entry.alu_result     = i_ex.alu_result;
    w_in_entry.rt_data        = i_ex.rt_data;
    w_in_entry.pc_target      = branch_target(i_ex.pc_plus4, i_ex.imm_sext);
    w_in_entry.wr_reg         = i_ex.wr_reg;
    w_in_entry.ctl.reg_write  = i_ex.ctl_reg_write;
    w_in_entry.ctl.mem_read   = i_ex.ctl_mem_read;
    w_in_entry.ctl.mem_write  = i_ex.ctl_mem_write;
    w_in_entry.ctl.mem_to_reg = i_ex.ctl_mem_to_reg;
    w_in_entry.taken          = i_ex.ctl_branch &
                                (i_ex.ctl_branch_ne ? ~i_ex.alu_zero : i_ex.alu_zero);
  end

  exmem_skid #(.T(exmem_entry_t)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_ex.flush),
    .i_valid (i_ex.in_valid),
    .o_ready (i_ex.in_ready),
    .i_data  (w_in_entry),
    .o_valid (w_head_valid),
    .i_ready (o_mem.out_ready),
    .o_data  (w_head),
    .o_state (o_mem.skid_state)
  );

  assign o_mem.out_valid      = w_head_valid;
  assign o_mem.out_alu_result = w_head.alu_result;
  assign o_mem.out_rt_data    = w_head.rt_data;
  assign o_mem.out_pc_target  = w_head.pc_target;
  assign o_mem.out_wr_reg     = w_head.wr_reg;
  assign o_mem.out_reg_write  = w_head.ctl.reg_write;
  assign o_mem.out_mem_read   = w_head.ctl.mem_read;
  assign o_mem.out_mem_write  = w_head.ctl.mem_write;
  assign o_mem.out_mem_to_reg = w_head.ctl.mem_to_reg;
  assign o_mem.br_taken       = w_head_valid & w_head.taken;

`ifdef EXMEM_FWD_EN
  // Loads are excluded: their data is not known until after MEM.
  assign o_mem.fwd_valid = w_head_valid & w_head.ctl.reg_write &
                           (w_head.wr_reg != REG_ZERO) & ~w_head.ctl.mem_read;
  assign o_mem.fwd_reg   = w_head.wr_reg;
  assign o_mem.fwd_data  = w_head.alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage: reset, streaming, backpressure, branch
// target/taken, flush, reset mid-stream and (with EXMEM_FWD_EN) forwarding.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_mem_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  exmem_in_if  ex_if ();
  exmem_out_if mem_if ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ex  (ex_if.slave),
    .o_mem (mem_if.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne}
  task automatic send(input logic v, input logic [31:0] alu, input logic zero,
                      input logic [31:0] rt, input logic [4:0] wr,
                      input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [5:0] ctl);
    ex_if.in_valid       = v;
    ex_if.alu_result     = alu;
    ex_if.alu_zero       = zero;
    ex_if.rt_data        = rt;
    ex_if.wr_reg         = wr;
    ex_if.pc_plus4       = pc4;
    ex_if.imm_sext       = imm;
    ex_if.ctl_reg_write  = ctl[5];
    ex_if.ctl_mem_read   = ctl[4];
    ex_if.ctl_mem_write  = ctl[3];
    ex_if.ctl_mem_to_reg = ctl[2];
    ex_if.ctl_branch     = ctl[1];
    ex_if.ctl_branch_ne  = ctl[0];
  endtask

  task automatic send_alu(input logic [31:0] alu);
    send(1'b1, alu, 1'b0, 32'h0, 5'd1, 32'h0, 32'h0, 6'b100000);
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ex_if.flush = 1'b0;
    mem_if.out_ready = 1'b0;
    send(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 6'b0);

    // Reset state
    #3;
    chk("rst_out_valid", 64'(mem_if.out_valid), 64'd0);
    chk("rst_in_ready",  64'(ex_if.in_ready),   64'd1);
    chk("rst_br_taken",  64'(mem_if.br_taken),  64'd0);
    chk("rst_alu",       64'(mem_if.out_alu_result), 64'd0);
    #20 rst_n = 1'b1;
    step();

    // Streaming, no stalls
    mem_if.out_ready = 1'b1;
    send_alu(32'h11);
    step();
    chk("str_v0",   64'(mem_if.out_valid), 64'd1);
    chk("str_d0",   64'(mem_if.out_alu_result), 64'h11);
    chk("str_rdy0", 64'(ex_if.in_ready), 64'd1);
    send_alu(32'h22);
    step();
    chk("str_v1", 64'(mem_if.out_valid), 64'd1);
    chk("str_d1", 64'(mem_if.out_alu_result), 64'h22);
    send_alu(32'h33);
    step();
    chk("str_v2", 64'(mem_if.out_valid), 64'd1);
    chk("str_d2", 64'(mem_if.out_alu_result), 64'h33);
    ex_if.in_valid = 1'b0;
    step();
    chk("str_drain", 64'(mem_if.out_valid), 64'd0);

    // Backpressure
    mem_if.out_ready = 1'b0;
    send_alu(32'h11);
    step();
    chk("bp_rdy1",  64'(ex_if.in_ready), 64'd1);
    chk("bp_head1", 64'(mem_if.out_alu_result), 64'h11);
    send_alu(32'h22);
    step();
    chk("bp_rdy2",  64'(ex_if.in_ready), 64'd0);
    chk("bp_state", 64'(mem_if.skid_state), 64'(SKID_TWO));
    chk("bp_head2", 64'(mem_if.out_alu_result), 64'h11);
    send_alu(32'h33);
    step();
    chk("bp_rdy3",  64'(ex_if.in_ready), 64'd0);
    chk("bp_head3", 64'(mem_if.out_alu_result), 64'h11);
    mem_if.out_ready = 1'b1;
    step();
    chk("bp_out2_v", 64'(mem_if.out_valid), 64'd1);
    chk("bp_out2",   64'(mem_if.out_alu_result), 64'h22);
    chk("bp_rdy4",   64'(ex_if.in_ready), 64'd1);
    step();
    chk("bp_out3_v", 64'(mem_if.out_valid), 64'd1);
    chk("bp_out3",   64'(mem_if.out_alu_result), 64'h33);
    ex_if.in_valid = 1'b0;
    step();
    chk("bp_drain", 64'(mem_if.out_valid), 64'd0);

    // Branch resolution
    send(1'b1, 32'h0, 1'b1, 32'h5555, 5'd3, 32'h100, 32'hFFFF_FFFE, 6'b000010);
    step();
    chk("beq_target", 64'(mem_if.out_pc_target), 64'hF8);
    chk("beq_taken",  64'(mem_if.br_taken), 64'd1);
    chk("beq_rt",     64'(mem_if.out_rt_data), 64'h5555);
    send(1'b1, 32'h0, 1'b1, 32'h0, 5'd0, 32'h200, 32'h4, 6'b000011);
    step();
    chk("bne_z1_taken", 64'(mem_if.br_taken), 64'd0);
    chk("bne_target",   64'(mem_if.out_pc_target), 64'h210);
    send(1'b1, 32'h1, 1'b0, 32'h0, 5'd0, 32'h200, 32'h4, 6'b000011);
    step();
    chk("bne_z0_taken", 64'(mem_if.br_taken), 64'd1);
    send(1'b1, 32'h1, 1'b0, 32'h0, 5'd0, 32'h200, 32'h4, 6'b000010);
    step();
    chk("beq_z0_taken", 64'(mem_if.br_taken), 64'd0);
    send(1'b1, 32'h0, 1'b1, 32'hDEAD, 5'd9, 32'h0, 32'h0, 6'b011100);
    step();
    chk("nobr_taken", 64'(mem_if.br_taken), 64'd0);
    chk("ctl_rw",  64'(mem_if.out_reg_write), 64'd0);
    chk("ctl_mr",  64'(mem_if.out_mem_read), 64'd1);
    chk("ctl_mw",  64'(mem_if.out_mem_write), 64'd1);
    chk("ctl_m2r", 64'(mem_if.out_mem_to_reg), 64'd1);
    chk("ctl_wr",  64'(mem_if.out_wr_reg), 64'd9);
    // Taken bit of an invalid head must not leak
    send(1'b1, 32'h0, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 6'b000010);
    step();
    ex_if.in_valid = 1'b0;
    step();
    chk("br_gated", 64'(mem_if.br_taken), 64'd0);

`ifdef EXMEM_FWD_EN
    send(1'b1, 32'hABCD, 1'b0, 32'h0, 5'd8, 32'h0, 32'h0, 6'b100000);
    step();
    chk("fwd_valid", 64'(mem_if.fwd_valid), 64'd1);
    chk("fwd_reg",   64'(mem_if.fwd_reg), 64'd8);
    chk("fwd_data",  64'(mem_if.fwd_data), 64'hABCD);
    send(1'b1, 32'hABCD, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 6'b100000);
    step();
    chk("fwd_r0", 64'(mem_if.fwd_valid), 64'd0);
    send(1'b1, 32'hABCD, 1'b0, 32'h0, 5'd8, 32'h0, 32'h0, 6'b110100);
    step();
    chk("fwd_load", 64'(mem_if.fwd_valid), 64'd0);
    ex_if.in_valid = 1'b0;
    step();
    chk("fwd_empty", 64'(mem_if.fwd_valid), 64'd0);
`endif

    // Flush with two held plus an input in the flush cycle
    mem_if.out_ready = 1'b0;
    send_alu(32'hA1);
    step();
    send_alu(32'hA2);
    step();
    send_alu(32'hA3);
    ex_if.flush = 1'b1;
    step();
    chk("fl_valid", 64'(mem_if.out_valid), 64'd0);
    chk("fl_ready", 64'(ex_if.in_ready), 64'd1);
    // Flush with input accepted and output ready in the same cycle
    ex_if.flush = 1'b0;
    mem_if.out_ready = 1'b1;
    send_alu(32'hB1);
    step();
    chk("fl2_pre", 64'(mem_if.out_alu_result), 64'hB1);
    send_alu(32'hB2);
    ex_if.flush = 1'b1;
    step();
    chk("fl2_valid", 64'(mem_if.out_valid), 64'd0);
    ex_if.flush = 1'b0;
    ex_if.in_valid = 1'b0;
    step();
    chk("fl2_after", 64'(mem_if.out_valid), 64'd0);

    // Reset mid-stream with two entries held
    mem_if.out_ready = 1'b0;
    send(1'b1, 32'h77, 1'b1, 32'h99, 5'd4, 32'h100, 32'h1, 6'b100010);
    step();
    send(1'b1, 32'h78, 1'b1, 32'h9A, 5'd5, 32'h100, 32'h2, 6'b100010);
    step();
    chk("mr_pre_state", 64'(mem_if.skid_state), 64'(SKID_TWO));
    chk("mr_pre_taken", 64'(mem_if.br_taken), 64'd1);
    ex_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid",  64'(mem_if.out_valid), 64'd0);
    chk("mr_ready",  64'(ex_if.in_ready), 64'd1);
    chk("mr_taken",  64'(mem_if.br_taken), 64'd0);
    chk("mr_alu",    64'(mem_if.out_alu_result), 64'd0);
    chk("mr_rt",     64'(mem_if.out_rt_data), 64'd0);
    chk("mr_target", 64'(mem_if.out_pc_target), 64'd0);
    chk("mr_wr",     64'(mem_if.out_wr_reg), 64'd0);
    chk("mr_rw",     64'(mem_if.out_reg_write), 64'd0);
    #2 rst_n = 1'b1;
    step();
    chk("mr_after", 64'(mem_if.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
